// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: two-master (IFU read-only, LSU read/write) to one-slave
// AXI4-Lite-style arbiter. A grant is held for one full transaction, from the
// address phase through the response, and the response goes back only to the
// granted requester.
// Build option: YSYX_ARB_RR_EN selects round-robin conflict resolution.
// Without it, LSU always wins conflicts.
module ysyx_bus_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read port
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  // LSU read port
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  // LSU write port
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  // slave AR channel
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  // slave R channel
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready,
  // slave AW channel
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  // slave W channel
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  // slave B channel
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IFU_RD = 2'd1,
    S_LSU_RD = 2'd2,
    S_LSU_WR = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  logic lsu_req;
  logic pick_lsu;
  logic gnt_ifu;
  logic gnt_lsu_rd;
  logic gnt_lsu_wr;
  logic r_done;
  logic b_done;

  assign lsu_req = lsu_awvalid | lsu_arvalid;
  assign r_done  = m_rvalid & m_rready;
  assign b_done  = m_bvalid & m_bready;

`ifdef YSYX_ARB_RR_EN
  // last granted master: 0 = IFU, 1 = LSU
  logic last_grant_q;

  // round-robin: on a conflict, favour the master that was not granted last
  always_comb begin
    pick_lsu = lsu_req;
    if (lsu_req && ifu_arvalid) begin
      pick_lsu = (last_grant_q == 1'b0);
    end
  end

  // remember the winner of every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else if (gnt_ifu) begin
      last_grant_q <= 1'b0;
    end else if (gnt_lsu_rd || gnt_lsu_wr) begin
      last_grant_q <= 1'b1;
    end
  end
`else
  // fixed priority: any LSU request beats IFU
  always_comb begin
    pick_lsu = lsu_req;
  end
`endif

  // grant decode, evaluated only in IDLE; a write beats a read within LSU
  always_comb begin
    gnt_ifu    = 1'b0;
    gnt_lsu_rd = 1'b0;
    gnt_lsu_wr = 1'b0;
    if (state_q == S_IDLE) begin
      if (pick_lsu) begin
        if (lsu_awvalid) gnt_lsu_wr = 1'b1;
        else             gnt_lsu_rd = 1'b1;
      end else if (ifu_arvalid) begin
        gnt_ifu = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic; each transaction returns to IDLE, which gives the bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_lsu_wr)      state_d = S_LSU_WR;
        else if (gnt_lsu_rd) state_d = S_LSU_RD;
        else if (gnt_ifu)    state_d = S_IFU_RD;
      end
      S_IFU_RD, S_LSU_RD: begin
        if (r_done) state_d = S_IDLE;
      end
      S_LSU_WR: begin
        if (b_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered slave-side channel controls and payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= STRB_W'(0);
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_lsu_wr) begin
            m_awaddr  <= lsu_awaddr;
            m_wdata   <= lsu_wdata;
            m_wstrb   <= lsu_wstrb;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end else if (gnt_lsu_rd) begin
            m_araddr  <= lsu_araddr;
            m_arvalid <= 1'b1;
          end else if (gnt_ifu) begin
            m_araddr  <= ifu_araddr;
            m_arvalid <= 1'b1;
          end
        end
        S_IFU_RD, S_LSU_RD: begin
          if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
          if (r_done) begin
            m_rready <= 1'b0;
          end
        end
        S_LSU_WR: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          // open B only once both AW and W have been accepted
          if (b_done) begin
            m_bready <= 1'b0;
          end else if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // response routing: only the granted requester sees rvalid/bvalid and data
  always_comb begin
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_bvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_rdata  = '0;
    if (state_q == S_IFU_RD && r_done) begin
      ifu_rvalid = 1'b1;
      ifu_rdata  = m_rdata;
    end
    if (state_q == S_LSU_RD && r_done) begin
      lsu_rvalid = 1'b1;
      lsu_rdata  = m_rdata;
    end
    if (state_q == S_LSU_WR && b_done) begin
      lsu_bvalid = 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Directed self-checking bench for ysyx_bus_arb (fixed priority by default,
// round-robin expectations when YSYX_ARB_RR_EN is defined).
module tb_ysyx_bus_arb;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic        m_bvalid;
  logic        m_bready;

  int tests;
  int fails;

  ysyx_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // slave side of one read: waits (bounded) for AR, accepts it next cycle,
  // returns data the cycle after, and samples the routed response
  task automatic slave_read(input logic [31:0] data, output logic [31:0] addr,
                            output logic iv, output logic [31:0] id,
                            output logic lv, output logic [31:0] ld,
                            output logic ok);
    ok = 1'b0; iv = 1'b0; lv = 1'b0; id = '0; ld = '0; addr = '0;
    for (int i = 0; i < 20 && !m_arvalid; i++) step();
    if (!m_arvalid) return;
    addr = m_araddr;
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    #1;
    iv = ifu_rvalid; id = ifu_rdata;
    lv = lsu_rvalid; ld = lsu_rdata;
    ok = m_rready;
    step();
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    #3;
    tests++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid});
    end
    tests++;
    if ({m_araddr, m_awaddr, m_wdata, m_wstrb} !== 100'h0) begin
      fails++;
      $display("FAIL reset_payload: got %h %h %h %h expected zeros", m_araddr, m_awaddr, m_wdata, m_wstrb);
    end
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_ifu_alone();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    step();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL ifu_ar_issue: got valid=%b addr=%h expected 1 80000000", m_arvalid, m_araddr);
    end
    ifu_arvalid = 1'b0;
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    tests++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin
      fails++;
      $display("FAIL ifu_ar_accept: got arvalid=%b rready=%b expected 0 1", m_arvalid, m_rready);
    end
    m_rvalid = 1'b1; m_rdata = 32'h0000_0413;
    #1;
    tests++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL ifu_resp: got ifu %b %h lsu %b %h expected ifu 1 00000413 lsu 0 0",
               ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata);
    end
    step();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    tests++;
    if (ifu_rvalid !== 1'b0 || m_rready !== 1'b0 || m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL ifu_pulse_end: got rvalid=%b rready=%b arvalid=%b expected 0 0 0", ifu_rvalid, m_rready, m_arvalid);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] addr, id, ld;
    logic        iv, lv, ok;
    logic        second_lsu;
`ifdef YSYX_ARB_RR_EN
    second_lsu = 1'b0;
`else
    second_lsu = 1'b1;
`endif
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
    step();
    // first conflict: LSU wins in both modes; LSU keeps requesting afterwards
    slave_read(32'h0000_AAAA, addr, iv, id, lv, ld, ok);
    tests++;
    if (ok !== 1'b1 || addr !== 32'h8000_1000 || lv !== 1'b1 || ld !== 32'h0000_AAAA || iv !== 1'b0) begin
      fails++;
      $display("FAIL conflict_first: got ok=%b addr=%h lsu %b %h ifu %b expected 1 80001000 lsu 1 0000aaaa ifu 0",
               ok, addr, lv, ld, iv);
    end
    tests++;
    if (m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL conflict_bubble: got arvalid=%b expected 0", m_arvalid);
    end
    step();
    if (second_lsu) lsu_arvalid = 1'b0;
    else            ifu_arvalid = 1'b0;
    slave_read(32'h0000_BBBB, addr, iv, id, lv, ld, ok);
    tests++;
    if (ok !== 1'b1 || addr !== (second_lsu ? 32'h8000_1000 : 32'h8000_0004) ||
        lv !== second_lsu || iv !== !second_lsu || (second_lsu ? ld : id) !== 32'h0000_BBBB) begin
      fails++;
      $display("FAIL conflict_second: got ok=%b addr=%h lsu %b %h ifu %b %h expected lsu_won=%b data 0000bbbb",
               ok, addr, lv, ld, iv, id, second_lsu);
    end
    step();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    slave_read(32'h0000_CCCC, addr, iv, id, lv, ld, ok);
    tests++;
    if (ok !== 1'b1 || addr !== (second_lsu ? 32'h8000_0004 : 32'h8000_1000) ||
        lv !== !second_lsu || iv !== second_lsu || (second_lsu ? id : ld) !== 32'h0000_CCCC) begin
      fails++;
      $display("FAIL conflict_third: got ok=%b addr=%h lsu %b %h ifu %b %h expected ifu_won=%b data 0000cccc",
               ok, addr, lv, ld, iv, id, second_lsu);
    end
  endtask

  task automatic test_write();
    lsu_awaddr = 32'h8000_2000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_awvalid = 1'b1;
    step();
    tests++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_bready !== 1'b0 || m_awaddr !== 32'h8000_2000 ||
        m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'hF) begin
      fails++;
      $display("FAIL wr_issue: got aw=%b w=%b b=%b %h %h %h expected 1 1 0 80002000 deadbeef f",
               m_awvalid, m_wvalid, m_bready, m_awaddr, m_wdata, m_wstrb);
    end
    lsu_awvalid = 1'b0;
    m_wready = 1'b1;
    step();
    m_wready = 1'b0;
    step();
    tests++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b0 || m_bready !== 1'b0) begin
      fails++;
      $display("FAIL wr_w_only: got aw=%b w=%b bready=%b expected 1 0 0", m_awvalid, m_wvalid, m_bready);
    end
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    tests++;
    if (m_awvalid !== 1'b0 || m_bready !== 1'b1) begin
      fails++;
      $display("FAIL wr_both_acc: got aw=%b bready=%b expected 0 1", m_awvalid, m_bready);
    end
    m_bvalid = 1'b1;
    #1;
    tests++;
    if (lsu_bvalid !== 1'b1 || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL wr_bvalid: got bvalid=%b ifu_rv=%b lsu_rv=%b expected 1 0 0", lsu_bvalid, ifu_rvalid, lsu_rvalid);
    end
    step();
    m_bvalid = 1'b0;
    #1;
    tests++;
    if (lsu_bvalid !== 1'b0 || m_bready !== 1'b0) begin
      fails++;
      $display("FAIL wr_pulse_end: got bvalid=%b bready=%b expected 0 0", lsu_bvalid, m_bready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, id, ld;
    logic        iv, lv, ok;
    lsu_awaddr = 32'h8000_3000; lsu_wdata = 32'h1111_2222; lsu_wstrb = 4'h3; lsu_awvalid = 1'b1;
    lsu_araddr = 32'h8000_3004; lsu_arvalid = 1'b1;
    step();
    tests++;
    if (m_awvalid !== 1'b1 || m_arvalid !== 1'b0 || m_wstrb !== 4'h3) begin
      fails++;
      $display("FAIL b2b_write_first: got aw=%b ar=%b strb=%h expected 1 0 3", m_awvalid, m_arvalid, m_wstrb);
    end
    lsu_awvalid = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1;
    #1;
    tests++;
    if (lsu_bvalid !== 1'b1 || m_bready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_bresp: got bvalid=%b bready=%b expected 1 1", lsu_bvalid, m_bready);
    end
    step();
    m_bvalid = 1'b0;
    tests++;
    if (m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_bubble: got arvalid=%b expected 0", m_arvalid);
    end
    step();
    lsu_arvalid = 1'b0;
    slave_read(32'h3333_4444, addr, iv, id, lv, ld, ok);
    tests++;
    if (ok !== 1'b1 || addr !== 32'h8000_3004 || lv !== 1'b1 || ld !== 32'h3333_4444 || iv !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read: got ok=%b addr=%h lsu %b %h ifu %b expected 1 80003004 1 33334444 0",
               ok, addr, lv, ld, iv);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] addr, id, ld;
    logic        iv, lv, ok;
    ifu_araddr = 32'h8000_0010; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    rst = 1'b0;
    #1;
    m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
    #1;
    tests++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid} !== 8'h00 ||
        m_araddr !== 32'h0 || ifu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got ctrl=%b araddr=%h ifu_rdata=%h expected 0 0 0",
               {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid},
               m_araddr, ifu_rdata);
    end
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    rst = 1'b1;
    step();
    tests++;
    if (ifu_rvalid !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got rvalid=%b arvalid=%b rready=%b expected 0 0 0", ifu_rvalid, m_arvalid, m_rready);
    end
    ifu_araddr = 32'h8000_0020; ifu_arvalid = 1'b1;
    step();
    ifu_arvalid = 1'b0;
    slave_read(32'h0000_0093, addr, iv, id, lv, ld, ok);
    tests++;
    if (ok !== 1'b1 || addr !== 32'h8000_0020 || iv !== 1'b1 || id !== 32'h0000_0093 || lv !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_read: got ok=%b addr=%h ifu %b %h lsu %b expected 1 80000020 1 00000093 0",
               ok, addr, iv, id, lv);
    end
  endtask

  task automatic test_spurious();
    m_rvalid = 1'b1; m_rdata = 32'h0000_1234; m_bvalid = 1'b1;
    #1;
    tests++;
    if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || lsu_bvalid !== 1'b0 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL spurious_idle: got ifu %b %h lsu %b %h b %b expected all 0",
               ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata, lsu_bvalid);
    end
    step();
    tests++;
    if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
      fails++;
      $display("FAIL spurious_stay_idle: got ifu_rv=%b lsu_rv=%b ar=%b aw=%b expected 0 0 0 0",
               ifu_rvalid, lsu_rvalid, m_arvalid, m_awvalid);
    end
    m_rvalid = 1'b0; m_rdata = '0; m_bvalid = 1'b0;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ifu_alone();
    step();
    test_conflict();
    step();
    test_write();
    step();
    test_back_to_back();
    step();
    test_async_reset();
    step();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
